kbd_scan_ctrl: RTL and testbench

Matrix scan controller for the ZX81 keyboard interface. Drives the eight keyboard row lines one at a time, waits a settle time, samples the five column lines through a synchroniser and debounces each row. It keeps a stable 8×5 key-state buffer for the Z80 bus responder, which reads half-rows through an address-mask port. It replaces free-running per-clock row capture with a sequenced, debounced scan that the bus side can pause.

---
 rtl/kbd_pkg.sv | 8 +
 rtl/kbd_row_debounce.sv | 31 +++
 rtl/kbd_scan_ctrl.sv | 87 ++++++++
 tb/tb_kbd_scan_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// kbd_pkg: shared sizes, scan FSM states and the released-key pattern for the ZX81 keyboard scanner
package kbd_pkg;
  localparam int NUM_ROWS = 8;
  localparam int NUM_COLS = 5;
  localparam int ROW_W = $clog2(NUM_ROWS);
  localparam logic [NUM_COLS-1:0] KEY_RELEASED = 5'h1F;
  typedef enum logic [1:0] {DRIVE, SETTLE, SAMPLE, GAP} scan_state_t;
endpackage

// File: rtl/kbd_row_debounce.sv
// kbd_row_debounce: commits a row's column sample once it has been seen DB_SCANS times in a row
module kbd_row_debounce
  import kbd_pkg::*;
#(
  parameter int DB_SCANS = 3
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                sample_en,
  input  logic [NUM_COLS-1:0] s,
  output logic [NUM_COLS-1:0] stable
);
  localparam int CW = $clog2(DB_SCANS + 1);
  localparam logic [CW-1:0] CMAX = CW'(DB_SCANS);
  logic [NUM_COLS-1:0] cand;
  logic [CW-1:0] cnt;
  logic [CW-1:0] n;
  assign n = s != cand ? CW'(1) : (cnt == CMAX ? CMAX : cnt + CW'(1));
  // a new candidate restarts the run; reaching the run length commits the sample in the same cycle
  always_ff @(posedge CLK) begin
    if (RST) begin
      cand <= KEY_RELEASED;
      cnt <= '0;
      stable <= KEY_RELEASED;
    end else if (sample_en) begin
      cand <= s;
      cnt <= n;
      if (n == CMAX) stable <= s;
    end
  end
endmodule

// File: rtl/kbd_scan_ctrl.sv
// kbd_scan_ctrl: sequenced, debounced 8x5 keyboard matrix scan with a pausable sample point
module kbd_scan_ctrl
  import kbd_pkg::*;
#(
  parameter int SETTLE_CYC = 16,
  parameter int DB_SCANS = 3,
  parameter int SCAN_GAP = 0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [NUM_COLS-1:0] C,
  input  logic                hold,
  input  logic [NUM_ROWS-1:0] row_mask,
  output logic [NUM_ROWS-1:0] ROW_N,
  output logic [NUM_COLS-1:0] key_data,
  output logic                scan_done
);
  localparam int TMAX = SETTLE_CYC > SCAN_GAP ? SETTLE_CYC : SCAN_GAP;
  localparam int TW = $clog2(TMAX + 1);
  scan_state_t state, state_nx;
  logic [ROW_W-1:0] row, row_nx;
  logic [TW-1:0] tmr, tmr_nx;
  logic [NUM_ROWS-1:0] rown_nx;
  logic done_nx, sample_en, last_row;
  logic [NUM_COLS-1:0] c_s1, c_s2;
  logic [NUM_ROWS-1:0][NUM_COLS-1:0] stable;
  assign last_row = row == ROW_W'(NUM_ROWS - 1);
  assign sample_en = state == SAMPLE && !hold;
  // column synchroniser plus FSM, row, timer and output registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      c_s1 <= KEY_RELEASED;
      c_s2 <= KEY_RELEASED;
      state <= DRIVE;
      row <= '0;
      tmr <= '0;
      ROW_N <= '1;
      scan_done <= 1'b0;
    end else begin
      c_s1 <= C;
      c_s2 <= c_s1;
      state <= state_nx;
      row <= row_nx;
      tmr <= tmr_nx;
      ROW_N <= rown_nx;
      scan_done <= done_nx;
    end
  end
  // next-state: drive a row, let it settle, sample once hold clears, optionally idle between frames
  always_comb begin
    state_nx = state;
    row_nx = row;
    tmr_nx = tmr + TW'(1);
    rown_nx = ROW_N;
    done_nx = 1'b0;
    case (state)
      DRIVE: begin
        rown_nx = ~(NUM_ROWS'(1) << row);
        tmr_nx = '0;
        state_nx = SETTLE;
      end
      SETTLE: state_nx = tmr == TW'(SETTLE_CYC - 1) ? SAMPLE : SETTLE;
      SAMPLE: begin
        tmr_nx = '0;
        row_nx = hold ? row : row + ROW_W'(1);
        done_nx = !hold && last_row;
        rown_nx = !hold && last_row && SCAN_GAP > 0 ? '1 : ROW_N;
        state_nx = hold ? SAMPLE : (last_row && SCAN_GAP > 0 ? GAP : DRIVE);
      end
      default: state_nx = tmr == TW'(SCAN_GAP - 1) ? DRIVE : GAP;
    endcase
  end
  for (genvar g = 0; g < NUM_ROWS; g++) begin : g_row
    kbd_row_debounce #(.DB_SCANS(DB_SCANS)) u_db (
      .CLK(CLK),
      .RST(RST),
      .sample_en(sample_en && row == ROW_W'(g)),
      .s(c_s2),
      .stable(stable[g])
    );
  end
  // bus view: AND of the stable rows whose mask bit is low
  always_comb begin
    key_data = KEY_RELEASED;
    for (int i = 0; i < NUM_ROWS; i++) key_data &= row_mask[i] ? KEY_RELEASED : stable[i];
  end
endmodule

// File: tb/tb_kbd_scan_ctrl.sv
// tb_kbd_scan_ctrl: scoreboard bench; stimulus queues expectations, a monitor checks on scan_done or probes
module tb_kbd_scan_ctrl;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic hold = 1'b0;
  logic probe = 1'b0;
  logic [4:0] C;
  logic [7:0] row_mask = 8'hFF;
  logic [7:0] ROW_N;
  logic [4:0] key_data;
  logic scan_done;
  logic [7:0][4:0] pat = '1;
  int compared = 0;
  int mismatched = 0;
  int tick = 0;
  int last = 0;
  typedef struct {
    string tag;
    bit chk_r;
    logic [7:0] rown;
    bit chk_d;
    logic done;
    int nk;
    logic [2:0][7:0] m;
    logic [2:0][4:0] k;
    int len;
  } exp_t;
  exp_t q[$];

  kbd_scan_ctrl #(.SETTLE_CYC(4), .DB_SCANS(3), .SCAN_GAP(0)) dut (
    .CLK(CLK),
    .RST(RST),
    .C(C),
    .hold(hold),
    .row_mask(row_mask),
    .ROW_N(ROW_N),
    .key_data(key_data),
    .scan_done(scan_done)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) tick <= tick + 1;

  always_comb begin
    C = 5'h1F;
    for (int i = 0; i < 8; i++) if (!ROW_N[i]) C &= pat[i];
  end

  task automatic cmp(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic exp_t rec(input string tag, input logic [7:0] rown, input logic done, input int len);
    exp_t r;
    r.tag = tag;
    r.chk_r = 1'b1;
    r.rown = rown;
    r.chk_d = 1'b1;
    r.done = done;
    r.nk = 0;
    r.m = '1;
    r.k = '1;
    r.len = len;
    return r;
  endfunction

  function automatic exp_t addk(input exp_t r, input logic [7:0] m, input logic [4:0] k);
    exp_t o = r;
    o.m[o.nk] = m;
    o.k[o.nk] = k;
    o.nk++;
    return o;
  endfunction

  initial begin : monitor
    exp_t r;
    forever begin
      @(negedge CLK);
      if (RST) last = tick;
      if (scan_done || probe) begin
        if (q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL queue_underflow: output event with no expectation, scan_done=%0b probe=%0b", scan_done, probe);
        end else begin
          r = q.pop_front();
          if (r.chk_r) cmp({r.tag, ".row_n"}, int'(ROW_N), int'(r.rown));
          if (r.chk_d) cmp({r.tag, ".scan_done"}, int'(scan_done), int'(r.done));
          for (int j = 0; j < r.nk; j++) begin
            row_mask = r.m[j];
            #1;
            cmp($sformatf("%s.key_mask_%h", r.tag, r.m[j]), int'(key_data), int'(r.k[j]));
          end
          row_mask = 8'hFF;
          if (scan_done) begin
            if (r.len != 0) cmp({r.tag, ".frame_len"}, tick - last, r.len);
            last = tick;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #2;
    probe = 1'b0;
  endtask

  task automatic push_probe(input exp_t r);
    q.push_back(r);
    probe = 1'b1;
  endtask

  task automatic do_reset();
    step();
    RST = 1'b1;
    hold = 1'b0;
    step();
    step();
    push_probe(addk(rec("in_reset", 8'hFF, 1'b0, 0), 8'h00, 5'h1F));
    step();
    RST = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    do begin
      step();
      n++;
    end while (!scan_done && n < 200);
    if (!scan_done) begin
      compared++;
      mismatched++;
      $display("FAIL %s.timeout: no scan_done within %0d cycles", tag, n);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not complete, compared=%0d", compared);
    $fatal(1);
  end

  initial begin : stimulus
    logic [7:0] er;
    logic [5:0] present = 6'b111011;
    exp_t r;
    // reset state and the free-running row sequence
    do_reset();
    for (int c = 0; c < 48; c++) begin
      er = c == 0 ? 8'hFF : ~(8'h01 << ((c - 1) / 6));
      push_probe(rec($sformatf("sweep%0d", c), er, 1'b0, 0));
      if (c == 47) q.push_back(addk(rec("reset_f1", 8'h7F, 1'b1, 0), 8'h00, 5'h1F));
      step();
    end
    q.push_back(rec("reset_f2", 8'h7F, 1'b1, 48));
    wait_done("reset_f2");
    step();
    push_probe(rec("post_pulse", 8'hFE, 1'b0, 0));
    step();
    q.push_back(rec("reset_f3", 8'h7F, 1'b1, 48));
    wait_done("reset_f3");
    // single key on row 2
    pat = '1;
    pat[2] = 5'h1E;
    do_reset();
    for (int f = 1; f <= 3; f++) begin
      r = rec($sformatf("single_f%0d", f), 8'h7F, 1'b1, f == 1 ? 0 : 48);
      r = addk(r, 8'hFB, f == 3 ? 5'h1E : 5'h1F);
      r = addk(r, 8'h00, f == 3 ? 5'h1E : 5'h1F);
      r = addk(r, 8'hFE, 5'h1F);
      q.push_back(r);
      wait_done(r.tag);
    end
    // bouncing key: present, present, absent, then present three times
    pat = '1;
    do_reset();
    for (int f = 1; f <= 6; f++) begin
      pat[2] = present[f-1] ? 5'h1E : 5'h1F;
      if (f == 6) begin
        repeat (17) step();
        push_probe(addk(rec("bounce_presample", 8'hFB, 1'b0, 0), 8'hFB, 5'h1F));
        step();
        push_probe(addk(rec("bounce_postsample", 8'hFB, 1'b0, 0), 8'hFB, 5'h1E));
        step();
      end
      r = addk(rec($sformatf("bounce_f%0d", f), 8'h7F, 1'b1, f == 1 ? 0 : 48), 8'hFB, f == 6 ? 5'h1E : 5'h1F);
      q.push_back(r);
      wait_done(r.tag);
    end
    // hold on row 3: ten stalled cycles in SAMPLE, column glitch only before the real capture
    pat = '1;
    pat[3] = 5'h1E;
    do_reset();
    q.push_back(addk(rec("hold_f1", 8'h7F, 1'b1, 0), 8'hF7, 5'h1F));
    wait_done("hold_f1");
    repeat (20) step();
    hold = 1'b1;
    pat[3] = 5'h1F;
    for (int c = 20; c < 36; c++) begin
      if (c == 30) pat[3] = 5'h1E;
      if (c == 33) hold = 1'b0;
      push_probe(rec($sformatf("hold%0d", c), c == 35 ? 8'hEF : 8'hF7, 1'b0, 0));
      step();
    end
    q.push_back(addk(rec("hold_f2", 8'h7F, 1'b1, 58), 8'hF7, 5'h1F));
    wait_done("hold_f2");
    r = addk(addk(addk(rec("hold_f3", 8'h7F, 1'b1, 48), 8'hF7, 5'h1E), 8'h00, 5'h1E), 8'hFF, 5'h1F);
    q.push_back(r);
    wait_done("hold_f3");
    // keys on rows 0 and 7
    pat = '1;
    pat[0] = 5'h1D;
    pat[7] = 5'h0F;
    do_reset();
    for (int f = 1; f <= 3; f++) begin
      r = rec($sformatf("multi_f%0d", f), 8'h7F, 1'b1, f == 1 ? 0 : 48);
      r = addk(r, 8'h7E, f == 3 ? 5'h0D : 5'h1F);
      r = addk(r, 8'hFE, f == 3 ? 5'h1D : 5'h1F);
      r = addk(r, 8'h7F, f == 3 ? 5'h0F : 5'h1F);
      q.push_back(r);
      wait_done(r.tag);
    end
    // reset while row 5 is driven
    repeat (32) step();
    push_probe(addk(rec("mid_before", 8'hDF, 1'b0, 0), 8'h7E, 5'h0D));
    step();
    RST = 1'b1;
    step();
    RST = 1'b0;
    push_probe(addk(addk(addk(rec("mid_reset", 8'hFF, 1'b0, 0), 8'h7E, 5'h1F), 8'hFE, 5'h1F), 8'h7F, 5'h1F));
    step();
    push_probe(rec("mid_restart", 8'hFE, 1'b0, 0));
    step();
    q.push_back(addk(rec("mid_f1", 8'h7F, 1'b1, 0), 8'h7E, 5'h1F));
    wait_done("mid_f1");
    step();
    step();
    cmp("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
